// File: rtl/evm_cipher_pkg.sv
// EVM vote-record cipher: shared tables, constants and helpers.
// Bit 0 of every 64-bit block is the MSB.
package evm_cipher_pkg;

    localparam int BLOCK_W = 64;
    localparam int ROT_LSB = 58;

    typedef int tbl_t [64];

    // Forward: PMAP(x)[i] = x[PMAP_TBL[i]]
    localparam tbl_t PMAP_TBL = '{
        11, 48, 21, 58, 31,  4, 41, 14,
        51, 24, 61, 34,  7, 44, 17, 54,
        27,  0, 37, 10, 47, 20, 57, 30,
         3, 40, 13, 50, 23, 60, 33,  6,
        43, 16, 53, 26, 63, 36,  9, 46,
        19, 56, 29,  2, 39, 12, 49, 22,
        59, 32,  5, 42, 15, 52, 25, 62,
        35,  8, 45, 18, 55, 28,  1, 38
    };

    // Forward: IP(x)[i] = x[IP_TBL[i]]
    localparam tbl_t IP_TBL = '{
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7,
        56, 48, 40, 32, 24, 16,  8,  0,
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6
    };

    typedef enum logic [2:0] {
        IDLE,
        S_PMAP,
        S_XOR,
        S_IP,
        S_SHIFT
    } dec_state_t;

    // Undo a table permutation: y[tbl[i]] = x[i]
    function automatic logic [0:63] perm_inv(
        input logic [0:63] x,
        input tbl_t        tbl
    );
        logic [0:63] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[6'(tbl[i])] = x[6'(i)];
        end
        return y;
    endfunction

    // Rotate toward the LSB end; n = 0 passes x through
    function automatic logic [0:63] rotr64(
        input logic [0:63] x,
        input logic [5:0]  n
    );
        logic [6:0] s;
        s = 7'd64 - {1'b0, n};
        return (x >> n) | (x << s);
    endfunction

endpackage

// File: rtl/decrypter_inverse_permute.sv
// Combinational table-driven inverse bit permutation.
// The table is a module parameter so one body serves PMAP and IP.
module inverse_permute
    import evm_cipher_pkg::*;
#(
    parameter tbl_t TBL = PMAP_TBL
) (
    input  logic [0:63] i_x,
    output logic [0:63] o_y
);

    assign o_y = perm_inv(i_x, TBL);

endmodule

// File: rtl/decrypter.sv
// EVM vote-record decrypter: one inverse stage per clock,
// PMAP^-1, XOR key, IP^-1, rotate right.
module decrypter
    import evm_cipher_pkg::*;
#(
    parameter int ROT_BITS       = 6,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:63] data_in,
    input  logic [0:63] key_in,
    input  logic        start,
    output logic        busy,
    output logic        status,
    output logic [0:63] data_out
);

    localparam logic [5:0] ROT_MASK = 6'((1 << ROT_BITS) - 1);

    dec_state_t  r_state;
    dec_state_t  w_next;
    logic [0:63] r_work;
    logic [0:63] r_key;
    logic [0:63] r_data_out;
    logic        r_busy;
    logic        r_status;
    logic [0:63] w_pmap_inv;
    logic [0:63] w_ip_inv;
    logic [5:0]  w_rot;

    assign w_rot    = r_key[ROT_LSB:BLOCK_W-1] & ROT_MASK;
    assign busy     = r_busy;
    assign status   = r_status;
    assign data_out = r_data_out;

    inverse_permute #(
        .TBL (PMAP_TBL)
    ) u_pmap_inv (
        .i_x (r_work),
        .o_y (w_pmap_inv)
    );

    inverse_permute #(
        .TBL (IP_TBL)
    ) u_ip_inv (
        .i_x (r_work),
        .o_y (w_ip_inv)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: fixed walk through the four stages
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = S_PMAP;
            S_PMAP:  w_next = S_XOR;
            S_XOR:   w_next = S_IP;
            S_IP:    w_next = S_SHIFT;
            S_SHIFT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and handshake outputs, one stage per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_key      <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_status   <= 1'b0;
        end else begin
            r_status <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= data_in;
                        r_key  <= key_in;
                        r_busy <= 1'b1;
                        if (CLEAR_ON_START) begin
                            r_data_out <= '0;
                        end
                    end
                end
                S_PMAP: r_work <= w_pmap_inv;
                S_XOR:  r_work <= r_work ^ r_key;
                S_IP:   r_work <= w_ip_inv;
                S_SHIFT: begin
                    r_data_out <= rotr64(r_work, w_rot);
                    r_status   <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    // An unknown start while idle would make acceptance undefined
    a_start_known: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) |-> !$isunknown(start)
    );

endmodule
